rsa_mont_mul: RTL and testbench
===============================

Name: rsa_mont_mul

Overview:
- Responder end of the RSA core's multiply handshake: accepts start, two operands and modulus; returns the Montgomery product a·b·2^-WIDTH mod n with a one-cycle done pulse.
- Bit-serial (radix-2) iterative engine: one operand bit per cycle, then a single conditional final subtraction.
- Sits beside the RSA exponentiation core and is driven by its start-multiply, modcall1/modcall2 and n outputs.

Parameters:
- WIDTH, 256, operand/result width in bits; must be even, ≥4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  request, level-sensitive; sampled only in S_IDLE.
- i_a  in  WIDTH  multiplicand; bit i consumed in iteration i.
- i_b  in  WIDTH  multiplier operand.
- i_n  in  WIDTH+1  modulus; bit WIDTH ignored (must be 0); must be odd.
- o_result  out  WIDTH  Montgomery product, registered.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (i_rst=0, async): state S_IDLE, o_done=0, o_result=0, accumulator and counter cleared. Reset mid-operation abandons the operation; no done pulse.
- States: S_IDLE, S_CALC, S_FIX, S_DONE.
- S_IDLE: on i_start=1 at edge k, latch i_a, i_b, i_n[WIDTH-1:0]; clear accumulator m (WIDTH+2 bits) and counter (clog2(WIDTH) bits); go to S_CALC. Later operand changes are ignored until the next accepted start.
- S_CALC, one iteration per edge: t = m + (a[cnt] ? b : 0); if t[0], t = t + n; m = t >> 1; cnt++. After iteration WIDTH-1, at edge k+WIDTH, go to S_FIX.
- S_FIX: o_result = (m ≥ n) ? m − n : m, truncated to WIDTH; go to S_DONE (edge k+WIDTH+1).
- S_DONE: o_done=1 for this single cycle; go to S_IDLE unconditionally. i_start is ignored here, so a start still held high from the previous request cannot retrigger on stale operands.
- o_done = (state == S_DONE), registered.
- Latency: o_done is first high in the cycle after edge k+WIDTH+1 (WIDTH+1 clocks after the accepting edge). The earliest next accepting edge is k+WIDTH+3.
- o_result holds its value from S_FIX until the next S_FIX or reset.
- i_start during S_CALC, S_FIX or S_DONE: ignored, no queuing.
- Preconditions: i_a < n, i_b < n, n odd. Under these, m < 2n before S_FIX, so one subtraction suffices. Violating inputs give a deterministic but unspecified result; no hang.
- Width rule: accumulator is WIDTH+2 bits to hold m + b + n < 4n without overflow.
- Counter wrap: cnt wraps to 0 on leaving S_CALC; no wrap inside an operation.

Optional Feature:
- Macro RSA_MONT_RADIX4_EN.
- Defined: S_CALC performs two chained radix-2 iterations per edge, consuming a[cnt] then a[cnt+1]; cnt advances by 2. S_CALC lasts WIDTH/2 edges, and o_done is first high after edge k+WIDTH/2+1. Results are bit-identical to the radix-2 engine.
- Undefined: radix-2 timing as above.

Test Plan:
- WIDTH=8, n=13, a=5, b=7, single start pulse at edge k → o_done high exactly one cycle after edge k+9; o_result=1 (35·3 mod 13, since 2^-8 ≡ 3 mod 13).
- WIDTH=8, n=13, a=12, b=12 → o_result=3. Same inputs with a=1, b=9 (R mod n) → o_result=1. Same inputs with a=0, b=11 → o_result=0.
- WIDTH=8, i_start held high continuously with operands changed to a=12, b=12 in the cycle o_done is high → first result 1 (a=5, b=7), exactly one done pulse, then a new operation starts from S_IDLE giving 3; no stale relaunch from S_DONE.
- i_a toggled and i_start pulsed during S_CALC → result unchanged from latched operands; latency unchanged.
- i_rst driven low at iteration 4 → o_done=0 and o_result=0 immediately; after release and a new start with a=5, b=7, n=13, o_result=1.
- WIDTH=256, random odd n with bit 255 set, a,b<n, 200 vectors checked against a software Montgomery model. Repeat with RSA_MONT_RADIX4_EN: identical results, done after WIDTH/2+1 edges.

Source files
------------

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery multiplier: o_result = a * b * 2^-WIDTH mod n, with a one-cycle o_done pulse.
// Define RSA_MONT_RADIX4_EN to retire two multiplier bits per clock instead of one.
module rsa_mont_mul #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH:0]   i_n,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done
);

    localparam int MW    = WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH);
`ifdef RSA_MONT_RADIX4_EN
    localparam int STEP  = 2;
`else
    localparam int STEP  = 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - STEP);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [MW-1:0]    r_m;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic [MW-1:0]    w_m_next;
    logic [WIDTH-1:0] w_fixed;
    logic             w_unused_n_msb;

    assign w_unused_n_msb = i_n[WIDTH];

    // One radix-2 step; m stays below 2n, so m + b + n < 4n fits in WIDTH+2 bits.
    function automatic logic [MW-1:0] mont_step(input logic [MW-1:0]    m,
                                                input logic             a_bit,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
        logic [MW-1:0] t;
        t = m + (a_bit ? {2'b00, b} : '0);
        if (t[0]) t = t + {2'b00, n};
        return t >> 1;
    endfunction

`ifdef RSA_MONT_RADIX4_EN
    logic [MW-1:0] w_m_half;
    assign w_m_half = mont_step(r_m, r_a[r_cnt], r_b, r_n);
    assign w_m_next = mont_step(w_m_half, r_a[r_cnt + 1'b1], r_b, r_n);
`else
    assign w_m_next = mont_step(r_m, r_a[r_cnt], r_b, r_n);
`endif

    assign w_fixed = (r_m >= {2'b00, r_n}) ? WIDTH'(r_m - {2'b00, r_n}) : r_m[WIDTH-1:0];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == LAST_CNT) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: operand registers are always loaded before use, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_start) begin
            r_a <= i_a;
            r_b <= i_b;
            r_n <= i_n[WIDTH-1:0];
        end
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_m      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_m   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_m   <= w_m_next;
                    r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(STEP);
                end
                S_FIX:   r_result <= w_fixed;
                default: ;
            endcase
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign o_result = r_result;
    assign o_done   = r_done;

endmodule

// File: tb/tb_rsa_mont_mul.sv
// Self-checking bench for rsa_mont_mul: directed WIDTH=8 cases plus 200 random WIDTH=256 vectors
// checked against an arithmetic Montgomery model; honours RSA_MONT_RADIX4_EN for expected latency.
module tb_rsa_mont_mul;

`ifdef RSA_MONT_RADIX4_EN
    localparam int LAT8   = 8 / 2 + 1;
    localparam int LAT256 = 256 / 2 + 1;
`else
    localparam int LAT8   = 8 + 1;
    localparam int LAT256 = 256 + 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic [8:0]   n8 = 9'd13;
    logic [7:0]   res8;
    logic         done8;
    logic         start256 = 1'b0;
    logic [255:0] a256 = '0;
    logic [255:0] b256 = '0;
    logic [256:0] n256 = 257'd1;
    logic [255:0] res256;
    logic         done256;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rsa_mont_mul #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8), .i_n(n8),
        .o_result(res8), .o_done(done8)
    );

    rsa_mont_mul #(.WIDTH(256)) dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(start256), .i_a(a256), .i_b(b256), .i_n(n256),
        .o_result(res256), .o_done(done256)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // a*b*2^-256 mod n; 2^-1 mod n is obtained by halving modulo the odd n.
    function automatic logic [255:0] ref_mont(input logic [255:0] a, input logic [255:0] b,
                                              input logic [255:0] n);
        logic [511:0] nn, rinv, x;
        nn   = {256'b0, n};
        rinv = 512'd1;
        for (int i = 0; i < 256; i++) rinv = rinv[0] ? (rinv + nn) >> 1 : rinv >> 1;
        x = ({256'b0, a} * {256'b0, b}) % nn;
        x = (x * rinv) % nn;
        return x[255:0];
    endfunction

    // Pulse start for one edge on the chosen DUT and count edges until o_done (bounded).
    task automatic pulse_and_wait(input bit wide, output int edges);
        @(negedge clk);
        if (wide) start256 = 1'b1;
        else      start8   = 1'b1;
        @(negedge clk);
        start8   = 1'b0;
        start256 = 1'b0;
        edges    = 0;
        while (((wide ? done256 : done8) !== 1'b1) && edges < 1000) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp);
        int edges;
        a8 = a;
        b8 = b;
        n8 = 9'd13;
        pulse_and_wait(1'b0, edges);
        check({tag, "_latency"}, 256'(edges), 256'(LAT8));
        check({tag, "_result"}, 256'(res8), 256'(exp));
        @(negedge clk);
        check({tag, "_single_pulse"}, 256'(done8), 256'(0));
    endtask

    initial begin
        int edges;
        int gap;
        logic [255:0] n, exp;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_done8", 256'(done8), 256'(0));
        check("reset_result8", 256'(res8), 256'(0));
        check("reset_done256", 256'(done256), 256'(0));
        check("reset_result256", res256, 256'(0));
        rst = 1'b1;
        @(negedge clk);

        // Directed WIDTH=8, n=13 (2^-8 = 3 mod 13)
        run8("a5_b7", 8'd5, 8'd7, 8'd1);
        run8("a12_b12", 8'd12, 8'd12, 8'd3);
        run8("a1_b9", 8'd1, 8'd9, 8'd1);
        run8("a0_b11", 8'd0, 8'd11, 8'd0);

        // Start held high across completion; new operands appear while done is high
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; n8 = 9'd13; start8 = 1'b1;
        @(negedge clk);
        edges = 0;
        while (done8 !== 1'b1 && edges < 1000) begin
            @(negedge clk);
            edges++;
        end
        check("held_first_latency", 256'(edges), 256'(LAT8));
        check("held_first_result", 256'(res8), 256'(1));
        a8 = 8'd12; b8 = 8'd12;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done8 !== 1'b1 && gap < 1000);
        check("held_relaunch_gap", 256'(gap), 256'(LAT8 + 2));
        check("held_second_result", 256'(res8), 256'(3));
        start8 = 1'b0;
        @(negedge clk);
        check("held_second_pulse_end", 256'(done8), 256'(0));

        // Operand churn and a stray start while calculating
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; n8 = 9'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        edges  = 0;
        while (done8 !== 1'b1 && edges < 1000) begin
            a8     = ~a8;
            b8     = b8 + 8'd1;
            start8 = (edges == 2);
            @(negedge clk);
            edges++;
        end
        start8 = 1'b0;
        check("churn_latency", 256'(edges), 256'(LAT8));
        check("churn_result", 256'(res8), 256'(1));
        @(negedge clk);
        check("churn_single_pulse", 256'(done8), 256'(0));

        // Reset in the middle of an operation
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd12; n8 = 9'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_done", 256'(done8), 256'(0));
        check("midrst_result", 256'(res8), 256'(0));
        repeat (LAT8) begin
            @(negedge clk);
            check("midrst_no_done", 256'(done8), 256'(0));
        end
        rst = 1'b1;
        run8("post_reset", 8'd5, 8'd7, 8'd1);

        // WIDTH=256 random vectors against the arithmetic model
        for (int v = 0; v < 200; v++) begin
            n = rand256();
            n[255] = 1'b1;
            n[0]   = 1'b1;
            a256 = rand256() % n;
            b256 = rand256() % n;
            n256 = {1'b0, n};
            exp  = ref_mont(a256, b256, n);
            pulse_and_wait(1'b1, edges);
            check($sformatf("rnd%0d_latency", v), 256'(edges), 256'(LAT256));
            check($sformatf("rnd%0d_result", v), res256, exp);
        end
        @(negedge clk);
        check("rnd_single_pulse", 256'(done256), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
